spaceship_hareket: RTL and testbench



---
 rtl/spaceship_pkg.sv | 34 +++
 rtl/spaceship_yon_lut.sv | 16 +
 rtl/spaceship_hareket.sv | 153 +++++++++++++++
 tb/tb_spaceship_hareket.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/spaceship_pkg.sv
// Shared constants, heading LUT helper and FSM states for ship motion.
package spaceship_pkg;

  localparam int ANGLE_W = 4;
  localparam int FRAC = 6;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  // sin(k * 22.5 deg) in Q.6 for k = 0..4
  localparam logic signed [7:0] QSIN [0:4] = '{
    8'sd0, 8'sd25, 8'sd45, 8'sd59, 8'sd64
  };

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_VEL   = 2'd2,
    S_POS   = 2'd3
  } state_e;

  // Odd quadrants walk the table backwards; the lower half negates.
  function automatic logic signed [7:0] sin_q6(
    input logic [ANGLE_W-1:0] a
  );
    logic [2:0] idx;
    logic signed [7:0] mag;
    idx = a[2] ? 3'(3'd4 - {1'b0, a[1:0]})
               : {1'b0, a[1:0]};
    mag = QSIN[idx];
    return a[3] ? -mag : mag;
  endfunction

endpackage

// File: rtl/spaceship_yon_lut.sv
// Heading to unit direction vector; screen Y grows downward.
module spaceship_yon_lut
  import spaceship_pkg::*;
(
  input  logic [ANGLE_W-1:0] angle_i,
  output logic signed [7:0]  dx_o,
  output logic signed [7:0]  dy_o
);

  logic [ANGLE_W-1:0] cos_a;

  assign cos_a = angle_i + ANGLE_W'(4);
  assign dx_o  = sin_q6(angle_i);
  assign dy_o  = -sin_q6(cos_a);

endmodule

// File: rtl/spaceship_hareket.sv
// Per-frame ship integrator: thrust, drag, speed clamp, edge wrap.
module spaceship_hareket
  import spaceship_pkg::*;
#(
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int START_X     = 320,
  parameter int START_Y     = 240,
  parameter int VMAX        = 4,
  parameter int ACCEL_SHIFT = 3
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic [ANGLE_W-1:0]  angle,
  input  logic                thrust,
  output logic [9:0]          pos_x,
  output logic [9:0]          pos_y,
  output logic                moving,
  output logic                update_done
);

  localparam int PW = 16;
  localparam int VW = 12;
  localparam int SW = PW + 2;

  localparam logic signed [VW:0] LIM =
    (VW+1)'(VMAX << FRAC);
  localparam logic signed [SW-1:0] WRAP_X =
    SW'(SCREEN_W << FRAC);
  localparam logic signed [SW-1:0] WRAP_Y =
    SW'(SCREEN_H << FRAC);
  localparam logic [PW-1:0] P0_X = PW'(START_X << FRAC);
  localparam logic [PW-1:0] P0_Y = PW'(START_Y << FRAC);

  state_e state_q, state_d;
  logic thrust_q, thrust_d;
  logic signed [7:0] ax_q, ax_d, ay_q, ay_d;
  logic signed [VW-1:0] vx_q, vx_d, vy_q, vy_d;
  logic [PW-1:0] px_q, px_d, py_q, py_d;
  logic moving_q, moving_d;
  logic done_q, done_d;
  logic signed [7:0] dx, dy;

  spaceship_yon_lut u_lut (
    .angle_i (angle),
    .dx_o    (dx),
    .dy_o    (dy)
  );

  function automatic logic signed [VW-1:0] vel_step(
    input logic signed [VW-1:0] v,
    input logic signed [7:0]    a,
    input logic                 thr
  );
    logic signed [VW:0] s;
    logic signed [VW-1:0] r;
    if (thr) begin
      s = {v[VW-1], v} + {{(VW-7){a[7]}}, a};
      if (s > LIM)       r = LIM[VW-1:0];
      else if (s < -LIM) r = 12'(-LIM);
      else               r = s[VW-1:0];
    end else if (v > -12'sd16 && v < 12'sd16) begin
      r = '0;
    end else begin
      r = v - (v >>> 4);
    end
    return r;
  endfunction

  // Speed is far below screen size, so one correction suffices.
  function automatic logic [PW-1:0] wrap(
    input logic [PW-1:0]        p,
    input logic signed [VW-1:0] v,
    input logic signed [SW-1:0] m
  );
    logic signed [SW-1:0] s;
    s = $signed({2'b00, p})
      + $signed({{(SW-VW){v[VW-1]}}, v});
    if (s >= m)          s = s - m;
    else if (s < 18'sd0) s = s + m;
    return s[PW-1:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    thrust_d = thrust_q;
    ax_d     = ax_q;
    ay_d     = ay_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    px_d     = px_q;
    py_d     = py_q;
    moving_d = moving_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_tick) state_d = S_LATCH;
      end
      S_LATCH: begin
        thrust_d = thrust;
        ax_d     = dx >>> ACCEL_SHIFT;
        ay_d     = dy >>> ACCEL_SHIFT;
        state_d  = S_VEL;
      end
      S_VEL: begin
        vx_d    = vel_step(vx_q, ax_q, thrust_q);
        vy_d    = vel_step(vy_q, ay_q, thrust_q);
        state_d = S_POS;
      end
      S_POS: begin
        px_d     = wrap(px_q, vx_q, WRAP_X);
        py_d     = wrap(py_q, vy_q, WRAP_Y);
        moving_d = (vx_q != '0) || (vy_q != '0);
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      thrust_q <= 1'b0;
      ax_q     <= '0;
      ay_q     <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      px_q     <= P0_X;
      py_q     <= P0_Y;
      moving_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      thrust_q <= thrust_d;
      ax_q     <= ax_d;
      ay_q     <= ay_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      px_q     <= px_d;
      py_q     <= py_d;
      moving_q <= moving_d;
      done_q   <= done_d;
    end
  end

  assign pos_x       = px_q[PW-1:FRAC];
  assign pos_y       = py_q[PW-1:FRAC];
  assign moving      = moving_q;
  assign update_done = done_q;

endmodule

// File: tb/tb_spaceship_hareket.sv
// Scoreboard bench for spaceship_hareket against an integer motion model.
module tb_spaceship_hareket;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       thrust = 1'b0;
  logic [3:0] angle = 4'd0;
  logic [9:0] pos_x, pos_y;
  logic       moving, update_done;

  spaceship_hareket dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .angle       (angle),
    .thrust      (thrust),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .moving      (moving),
    .update_done (update_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit mv;
    int t;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mpx, mpy, mvx, mvy;
  int lx = 320, ly = 240;
  bit lm = 1'b0;

  localparam int W64 = 640 * 64;
  localparam int H64 = 480 * 64;
  localparam int LIM = 4 * 64;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  function automatic int sin64(int k);
    int s[5] = '{0, 25, 45, 59, 64};
    k = k % 16;
    if (k <= 4)  return s[k];
    if (k <= 8)  return s[8 - k];
    if (k <= 12) return -s[k - 8];
    return -s[16 - k];
  endfunction

  function automatic int fdiv(int x, int d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  function automatic int clamp(int v);
    if (v > LIM)  return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  function automatic int drag(int v);
    if (v > -16 && v < 16) return 0;
    return v - fdiv(v, 16);
  endfunction

  task automatic model_reset();
    mpx = 320 * 64;
    mpy = 240 * 64;
    mvx = 0;
    mvy = 0;
  endtask

  task automatic model_frame(int a, bit thr);
    int ax, ay;
    ax = fdiv(sin64(a), 8);
    ay = fdiv(-sin64(a + 4), 8);
    if (thr) begin
      mvx = clamp(mvx + ax);
      mvy = clamp(mvy + ay);
    end else begin
      mvx = drag(mvx);
      mvy = drag(mvy);
    end
    mpx = ((mpx + mvx) % W64 + W64) % W64;
    mpy = ((mpy + mvy) % H64 + H64) % H64;
  endtask

  task automatic push_exp();
    exp_t e;
    e.x  = mpx / 64;
    e.y  = mpy / 64;
    e.mv = (mvx != 0) || (mvy != 0);
    e.t  = cyc + 4;
    q.push_back(e);
  endtask

  // Called at a negedge; leaves at least four idle edges before return.
  task automatic frame(int a, bit thr);
    angle      = 4'(a);
    thrust     = thr;
    frame_tick = 1'b1;
    model_frame(a, thr);
    push_exp();
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    angle  = 4'($urandom);
    thrust = 1'($urandom);
    repeat ($urandom_range(2, 4)) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      lx = 320;
      ly = 240;
      lm = 1'b0;
    end else if (update_done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_done: got update_done=1, expected 0 (cycle %0d)",
                 cyc);
      end else begin
        me = q.pop_front();
        check("pos_x", int'(pos_x), me.x);
        check("pos_y", int'(pos_y), me.y);
        check("moving", int'(moving), int'(me.mv));
        check("latency", cyc, me.t);
        lx = me.x;
        ly = me.y;
        lm = me.mv;
      end
      check("x_in_range", int'(pos_x < 10'd640), 1);
      check("y_in_range", int'(pos_y < 10'd480), 1);
    end else begin
      check("hold_x", int'(pos_x), lx);
      check("hold_y", int'(pos_y), ly);
      check("hold_moving", int'(moving), int'(lm));
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pos_x", int'(pos_x), 320);
    check("rst_pos_y", int'(pos_y), 240);
    check("rst_moving", int'(moving), 0);
    check("rst_done", int'(update_done), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    frame(0, 1'b1);
    repeat (210) frame(4, 1'b1);
    repeat (240) frame(12, 1'b1);
    repeat (150) frame(0, 1'b1);
    repeat (214) frame(8, 1'b1);
    repeat (60) frame($urandom_range(0, 15), 1'b0);
    check("drag_stopped", int'(moving), 0);

    angle      = 4'd2;
    thrust     = 1'b1;
    frame_tick = 1'b1;
    model_frame(2, 1'b1);
    push_exp();
    @(negedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (6) @(negedge clk);

    angle      = 4'd6;
    thrust     = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("abort_pos_x", int'(pos_x), 320);
    check("abort_pos_y", int'(pos_y), 240);
    check("abort_moving", int'(moving), 0);
    check("abort_done", int'(update_done), 0);
    repeat (6) @(negedge clk);

    repeat (300) frame($urandom_range(0, 15), 1'($urandom_range(0, 1)));

    repeat (8) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
